// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//   Connects a single-issue core's data-memory port to a simple req/ack bus.
//   Loads stall the core until read data returns. Stores either stall the same
//   way, or go into a small posted-write FIFO so the core can carry on. All
//   buffered writes reach the bus, in order, before any load is issued.
//
// Build option:
//   DMEM_BRIDGE_WBUF_EN  defined   -> posted-write buffer of WBUF_DEPTH entries
//                        undefined -> no buffer; every store stalls until acked
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cpu_addr/din    byte address and store data from the core
//   cpu_r/cpu_w     byte read/write strobes (write wins if both are set)
//   cpu_dout        last load data, updated on each read ack
//   cpu_stall       core holds its request while this is high
//   bus_req/we/addr/wdata/be  registered bus request, held until acked
//   bus_ack/rdata   slave completion and read data
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int XLEN       = 32,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic [XLEN-1:0]   cpu_din,
  input  logic [XLEN/8-1:0] cpu_r,
  input  logic [XLEN/8-1:0] cpu_w,
  output logic [XLEN-1:0]   cpu_dout,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int BW = XLEN / 8;
  localparam logic [XLEN-1:0] LANE_MASK = XLEN'(BW - 1);

`ifdef DMEM_BRIDGE_WBUF_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN, S_READ} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
`endif

  state_t            r_state;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [XLEN-1:0]   r_bus_addr;
  logic [XLEN-1:0]   r_bus_wdata;
  logic [BW-1:0]     r_bus_be;
  logic [XLEN-1:0]   r_cpu_dout;
  // High for the one cycle after a stalling access completes: the core still
  // presents that same request, so it must be released, not restarted.
  logic              r_done;

  logic              w_store;
  logic              w_load;
  logic              w_ack;
  logic [XLEN-1:0]   w_addr_al;

  assign w_store   = |cpu_w;
  assign w_load    = (|cpu_r) && !w_store;
  assign w_ack     = r_bus_req && bus_ack;
  assign w_addr_al = cpu_addr & ~LANE_MASK;

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;
  assign cpu_dout  = r_cpu_dout;

`ifdef DMEM_BRIDGE_WBUF_EN
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WBUF_DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [XLEN-1:0] r_wb_addr [WBUF_DEPTH];
  logic [XLEN-1:0] r_wb_data [WBUF_DEPTH];
  logic [BW-1:0]   r_wb_be   [WBUF_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_store_blk;
  logic [PW-1:0]   w_next_ptr;

  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = ((r_state == S_WRITE) || (r_state == S_DRAIN)) && w_ack;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign w_store_blk = w_full && !w_pop;
  assign w_push      = w_store && !w_store_blk;
  assign w_next_ptr  = r_rd_ptr + PW'(1);
  assign cpu_stall   = !rst && (w_store ? w_store_blk : (w_load && !r_done));

  // NOTE: the entry storage has no reset; the pointers and count alone say
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= w_addr_al;
      r_wb_data[r_wr_ptr] <= cpu_din;
      r_wb_be[r_wr_ptr]   <= cpu_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_next_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  // The buffer depth has no meaning without the buffer.
  logic w_unused_depth;
  assign w_unused_depth = ^WBUF_DEPTH;

  assign cpu_stall = !rst && ((r_state != S_IDLE) || ((w_store || w_load) && !r_done));
`endif

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, matching the hardware they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_cpu_dout  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
`ifdef DMEM_BRIDGE_WBUF_EN
        S_IDLE: begin
          if (r_count != '0) begin
            // A waiting load turns the write-out into a drain toward the read.
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b1;
            r_bus_addr  <= r_wb_addr[r_rd_ptr];
            r_bus_wdata <= r_wb_data[r_rd_ptr];
            r_bus_be    <= r_wb_be[r_rd_ptr];
            r_state     <= (w_load && !r_done) ? S_DRAIN : S_WRITE;
          end else if (w_load && !r_done) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= w_addr_al;
            r_bus_wdata <= '0;
            r_bus_be    <= cpu_r;
            r_state     <= S_READ;
          end
        end
        S_DRAIN: begin
          if (w_ack) begin
            if (r_count == ONE_CNT) begin
              r_bus_we    <= 1'b0;
              r_bus_addr  <= w_addr_al;
              r_bus_wdata <= '0;
              r_bus_be    <= cpu_r;
              r_state     <= S_READ;
            end else begin
              r_bus_addr  <= r_wb_addr[w_next_ptr];
              r_bus_wdata <= r_wb_data[w_next_ptr];
              r_bus_be    <= r_wb_be[w_next_ptr];
            end
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
`else
        S_IDLE: begin
          if (!r_done && w_store) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b1;
            r_bus_addr  <= w_addr_al;
            r_bus_wdata <= cpu_din;
            r_bus_be    <= cpu_w;
            r_state     <= S_WRITE;
          end else if (!r_done && w_load) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= w_addr_al;
            r_bus_wdata <= '0;
            r_bus_be    <= cpu_r;
            r_state     <= S_READ;
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
`endif
        S_READ: begin
          if (w_ack) begin
            r_bus_req  <= 1'b0;
            r_cpu_dout <= bus_rdata;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
